// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART constants and state encoding shared by the transmit and receive paths
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_STOP_BITS  = 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - free-running 0..OVERSAMPLE-1 bit timer with synchronous clear and wrap pulse
module tx_bit_timer #(
    parameter int OVERSAMPLE = uart_pkg::DEFAULT_OVERSAMPLE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // wrap marks the last cycle of a bit period; clear suppresses it
    assign wrap_o = !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_transmitter.sv
// rtl/tx_transmitter.sv - UART transmitter: pops a show-ahead FIFO and serialises start/data/parity/stop
module tx_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = DEFAULT_STOP_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 TxFE,
    output logic                 read_order,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 timer_clr;
    logic                 bit_wrap;

    assign timer_clr  = (state_q == IDLE);
    assign read_order = (state_q == IDLE) && !TxFE;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign done       = done_q;
    assign shift_nxt  = shift_q >> 1;

    tx_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk_i (baud_clk),
        .rst_ni(rst_n),
        .clr_i (timer_clr),
        .wrap_o(bit_wrap)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // parity is frozen at pop time so later FIFO head changes cannot leak in
                if (read_order) begin
                    shift_d = data_in;
                    par_d   = (^data_in) ^ ODD;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_wrap) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_wrap) begin
                    if (bit_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                        bit_d   = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_wrap) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_wrap) begin
                    if ((STOP_BITS == 1) || stop_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tx_transmitter.sv
// tb/tb_tx_transmitter.sv - scoreboard bench for tx_transmitter across three parameter sets
module tb_tx_transmitter;

    logic       clk = 1'b0;
    logic       rstn   [3];
    logic       fe     [3];
    logic [7:0] din    [3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       rd_w   [3];

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // dut 0: defaults; dut 1: odd parity, 2 stop bits, x4; dut 2: no parity
    tx_transmitter u_dut_a (
        .baud_clk(clk), .rst_n(rstn[0]), .data_in(din[0]), .TxFE(fe[0]),
        .read_order(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    tx_transmitter #(.PARITY_ODD(1), .STOP_BITS(2), .OVERSAMPLE(4)) u_dut_b (
        .baud_clk(clk), .rst_n(rstn[1]), .data_in(din[1]), .TxFE(fe[1]),
        .read_order(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    tx_transmitter #(.PARITY_EN(0)) u_dut_c (
        .baud_clk(clk), .rst_n(rstn[2]), .data_in(din[2]), .TxFE(fe[2]),
        .read_order(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    function automatic int os_of(input int id);
        return (id == 1) ? 4 : 16;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic t, input logic b, input logic d, input logic r);
        exp_t e;
        e = '{tx: t, busy: b, done: d, rd: r};
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic compare(input int id, input exp_t e);
        exp_t a;
        a = '{tx: tx_w[id], busy: busy_w[id], done: done_w[id], rd: rd_w[id]};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d line_state @%0t: tx,busy,done,read_order=%b required %b",
                     id, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, q0.pop_front());
        if (q1.size() > 0) compare(1, q1.pop_front());
        if (q2.size() > 0) compare(2, q2.pop_front());
    end

    // pat lists the line level of each bit period, first bit first
    task automatic play_frame(input int id, input string pat, input int stop_at, input bit toggle);
        int len;
        len = pat.len() * os_of(id);
        for (int c = 0; c < len && c < stop_at; c++) begin
            if (toggle) fe[id] = ((c % 7) < 3);
            push(id, pat.getc(c / os_of(id)) == "1", 1'b1, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic send(input int id, input logic [7:0] ws [3], input string ps [3],
                        input int n, input bit toggle);
        logic dp;
        dp = 1'b0;
        for (int k = 0; k < n; k++) begin
            din[id] = ws[k];
            fe[id]  = 1'b0;
            push(id, 1'b1, 1'b0, dp, 1'b1);
            step();
            fe[id]  = (k == n - 1);
            din[id] = (k == n - 1) ? ~ws[k] : ws[k + 1];
            play_frame(id, ps[k], 1 << 20, toggle);
            dp = 1'b1;
        end
        fe[id] = 1'b1;
        push(id, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        push(id, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0;
            fe[i]   = 1'b1;
            din[i]  = 8'h00;
        end
        step();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) push(i, 1'b1, 1'b0, 1'b0, 1'b0);
            if (r == 2) for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
            step();
        end

        send(0, '{8'hA5, 8'h00, 8'h00}, '{"01010010101", "", ""}, 1, 1'b0);
        send(0, '{8'h01, 8'h80, 8'h3C},
             '{"01000000011", "00000000111", "00011110001"}, 3, 1'b0);

        din[0] = 8'h3C;
        fe[0]  = 1'b0;
        push(0, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        fe[0]  = 1'b1;
        din[0] = 8'h00;
        play_frame(0, "00011110001", 50, 1'b0);
        rstn[0] = 1'b0;
        push(0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        push(0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        rstn[0] = 1'b1;
        send(0, '{8'hC3, 8'h00, 8'h00}, '{"01100001101", "", ""}, 1, 1'b0);

        send(1, '{8'h00, 8'h5A, 8'h00}, '{"000000000111", "001011010111", ""}, 2, 1'b1);
        send(2, '{8'hFF, 8'h00, 8'h00}, '{"0111111111", "", ""}, 1, 1'b0);

        step();
        step();
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_transmitter.md
TX_TRANSMITTER -- requirements
Module: tx_transmitter

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity; 1 selects odd parity.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 and 2.
REQ-005 Parameter OVERSAMPLE, default 16: baud_clk cycles per serial bit; legal range 2..64.
REQ-006 baud_clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low (one clock; fixed polarity and synchronicity).
REQ-008 data_in  input  DATA_BITS  head word of the Tx FIFO (show-ahead), valid whenever TxFE=0.
REQ-009 TxFE  input  1  Tx FIFO empty flag.
REQ-010 read_order  output  1  FIFO pop strobe; combinational, high when state=IDLE and TxFE=0.
REQ-011 tx  output  1  serial line, registered, idle-high.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  registered one-cycle pulse at the end of each frame.

Function
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: on an edge with TxFE=0, latch data_in into the shift register, set tx=0, clear the bit timer, and enter START; read_order is high during that same cycle.
REQ-016 Each START, DATA, PARITY and STOP bit holds tx for exactly OVERSAMPLE cycles, timed by a counter that runs 0..OVERSAMPLE-1 and wraps.
REQ-017 DATA: send LSB first; on each timer wrap, shift right and drive the next bit; leave DATA after DATA_BITS bits.
REQ-018 After DATA: enter PARITY if PARITY_EN=1, otherwise enter STOP.
REQ-019 Parity bit: XOR of the latched data bits for even parity; its inverse for odd parity.
REQ-020 Parity is computed from the latched word; later data_in changes do not affect the frame in progress.
REQ-021 STOP: tx=1 for STOP_BITS*OVERSAMPLE cycles; on the final cycle, return to IDLE and pulse done for one cycle.
REQ-022 Frame length: OVERSAMPLE*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles; default 176.
REQ-023 Back-to-back: IDLE lasts at least 1 cycle between frames, so frame start-to-start is 177 cycles at defaults.
REQ-024 TxFE transitions while busy are ignored; read_order is never high outside IDLE.
REQ-025 TxFE=1 in IDLE: remain in IDLE with tx=1, read_order=0, busy=0.
REQ-026 Bit and timer counters are sized to their maximum counts; no overflow at DATA_BITS=8 or OVERSAMPLE=64.

Reset
REQ-027 When rst_n=0, immediately set: state=IDLE, tx=1, busy=0, done=0, counters=0, shift register=0.
REQ-028 Reset asserted mid-frame aborts the frame; the word already popped is discarded and is not resent.
REQ-029 On the first edge after reset release with TxFE=0, a new frame starts normally.

Structure
REQ-030 Shared package uart_pkg holds the state encoding localparams and the default values of DATA_BITS, OVERSAMPLE and STOP_BITS, shared with the receive path.
REQ-031 One sub-module, tx_bit_timer: an OVERSAMPLE-cycle counter with clear input and wrap-pulse output; the FSM, shifter and parity logic stay in tx_transmitter.

Verification
REQ-032 Defaults, data_in=8'hA5, TxFE held low 1 cycle: read_order high for exactly 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 16 cycles; done pulses at cycle 176.
REQ-033 PARITY_ODD=1, data_in=8'h00: parity bit=1; PARITY_EN=0, data_in=8'hFF: frame is 160 cycles with no parity bit.
REQ-034 Three words queued (8'h01, 8'h80, 8'h3C) with TxFE low throughout: three frames start 177 cycles apart; 3 read_order pulses; 3 done pulses.
REQ-035 rst_n pulled low at cycle 50 of a frame: tx=1 and busy=0 in the same cycle; with TxFE low after release, the next frame starts on the first edge.
REQ-036 STOP_BITS=2, OVERSAMPLE=4: stop interval is 8 cycles high; total frame is 48 cycles; a TxFE toggle mid-frame produces no extra read_order.
